dsp_mac_sched: RTL and testbench
================================

Name: dsp_mac_sched

Overview:
- Shares one pipelined signed multiplier (the iCE40 DSP MAC instance, latency MUL_LAT) among NREQ requesters.
- Arbitrates round-robin, drives the DSP operands and tracks in-flight operations with a tag pipeline.
- Keeps one accumulator per requester and returns each updated accumulator on a per-requester response strobe.
- Sits between the calc-style datapath clients and the DSP wrapper.

Parameters:
- NREQ, 4, number of requesters (2..8)
- WIDTH, 16, signed operand width (DSP input width)
- ACC_WIDTH, 32, accumulator/result width; must be >= 2*WIDTH
- MUL_LAT, 2, register stages inside the external DSP from dsp_a/dsp_b to dsp_p (1..4)

Ports:
- clk  in  1  single clock, all logic rising-edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  NREQ  request strobe per requester
- req_ready  out  NREQ  accept per requester; handshake = valid & ready
- req_a  in  NREQ*WIDTH  signed operand A, requester i at [i*WIDTH +: WIDTH]
- req_b  in  NREQ*WIDTH  signed operand B, same packing
- req_acc  in  NREQ  1 = add product to accumulator, 0 = load product (clear-and-start)
- dsp_a  out  WIDTH  registered operand to DSP
- dsp_b  out  WIDTH  registered operand to DSP
- dsp_p  in  2*WIDTH  signed product, valid MUL_LAT cycles after dsp_a/dsp_b
- rsp_valid  out  NREQ  one-hot (or zero) result strobe, one cycle
- rsp_data  out  ACC_WIDTH  updated accumulator of the strobed requester
- busy  out  NREQ  requester has an operation in flight

Behaviour:
- Reset (async assert, sync deassert by the user): req_ready, rsp_valid, busy, dsp_a, dsp_b, rsp_data, all accumulators and all tag-pipeline valids = 0. RR pointer = 0. Any in-flight operation is discarded; a stale dsp_p is ignored because its tags are invalid.
- Eligibility: elig[i] = req_valid[i] & ~busy[i].
- Grant: combinational round-robin over elig, starting at the pointer. At most one grant per cycle. req_ready = one-hot grant; req_ready may depend on req_valid.
- Pointer: on a handshake by requester g, the pointer becomes (g+1) mod NREQ. It is unchanged when there is no grant.
- Accept, cycle 0 edge:
  - dsp_a/dsp_b <= operands of g; tag stage 0 <= {valid=1, id=g, acc=req_acc[g]}; busy[g] <= 1.
  - When there is no grant, dsp_a/dsp_b hold their value and the stage-0 valid = 0.
- Tag pipeline: MUL_LAT stages shifting every cycle, with no stall. The last stage aligns with dsp_p.
- Writeback edge (last stage valid, id k):
  - p = sign-extend(dsp_p) to ACC_WIDTH.
  - acc[k] <= acc ? acc[k]+p : p; the sum wraps modulo 2^ACC_WIDTH.
  - rsp_data <= new value; rsp_valid <= one-hot k for one cycle; busy[k] <= 0.
- Latency: handshake in cycle 0 -> rsp_valid high in cycle MUL_LAT+2.
- Per-requester issue period: MUL_LAT+2 cycles, because busy clears on the same edge that rsp_valid sets, so the requester is eligible in that cycle.
- Aggregate throughput: 1 op/cycle when NREQ >= MUL_LAT+2 and all requesters are active.
- Busy blocking removes accumulator read-after-write hazards; no forwarding is needed.
- Simultaneous events: accept of requester j and writeback of requester k≠j on the same edge are independent. j = k cannot occur because of busy.
- rsp_data holds its last value when rsp_valid = 0.
- No back-pressure on responses: the consumer must take rsp_valid in its strobe cycle.

Optional Feature:
- Macro DSP_MAC_SAT_EN.
- Defined: accumulate uses signed saturation; on overflow the result clamps to 2^(ACC_WIDTH-1)-1 or -2^(ACC_WIDTH-1). Load mode is unaffected.
- Undefined: two's-complement wrap. No extra logic is generated.

Decomposition:
- Shared include dsp_mac_defs.vh holds: default WIDTH/ACC_WIDTH/MUL_LAT, the tag field widths (id width = clog2 of NREQ), and saturation limit constants.
- One natural sub-module is rr_arbiter (parameter N; inputs elig and ptr; output one-hot grant). It is reusable by other shared-resource controllers.

Test Plan:
- Single op: NREQ=4, MUL_LAT=2, req0 a=3, b=-5, acc=0 in cycle 0 -> dsp_a=3 in cycle 1; rsp_valid=0001 and rsp_data=0xFFFFFFF1 in cycle 4; busy[0] low from cycle 4.
- Accumulate chain: req1 loads 100*200, then two accumulates of 7*8 re-issued as soon as ready -> rsp_data 20000, 20056, 20112; consecutive accepts spaced exactly 4 cycles apart.
- Fairness: all four requesters hold valid continuously -> grants 0,1,2,3,0,1,... with one accept per cycle and no requester starved. Each busy blocks re-grant until its response.
- Overlap: req2 accepted in cycle 0, req3 in cycle 1 -> rsp_valid 0100 in cycle 4, then 1000 in cycle 5, each with its own data. Busy bits do not interfere.
- Reset mid-flight: assert rst_n=0 one cycle after accepting req0 -> all outputs 0 immediately. After release, no rsp_valid appears for the discarded op and acc0 reads 0 on the next load.
- Saturation (DSP_MAC_SAT_EN): load 0x7FFF*0x7FFF, then accumulate the same product repeatedly -> rsp_data clamps at 0x7FFFFFFF. Without the macro, the same sequence wraps negative.

Source files
------------

// File: rtl/dsp_mac_sched_pkg.sv
// Shared definitions for the DSP MAC scheduler: default geometry and tag field sizing.
package dsp_mac_sched_pkg;

  localparam int DEF_NREQ      = 4;
  localparam int DEF_WIDTH     = 16;
  localparam int DEF_ACC_WIDTH = 32;
  localparam int DEF_MUL_LAT   = 2;

  // Requester-id width; never narrower than one bit so NREQ=2 still has a field.
  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/dsp_mac_sched_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first eligible requester at or after ptr.
// Purely combinational, reusable by any shared-resource controller.
module dsp_mac_sched_rr_arbiter #(
  parameter int N     = 4,
  parameter int PTR_W = 2
) (
  input  logic [N-1:0]     elig,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     grant
);

  // Scan from the pointer, wrapping, and take the first eligible requester.
  always_comb begin
    logic found;
    int   idx;
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int o = 0; o < N; o++) begin
      idx = (int'(ptr) + o) % N;
      if (!found && elig[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dsp_mac_sched.sv
// Scheduler sharing one pipelined signed multiplier among NREQ requesters, with one
// accumulator per requester. Optional macro DSP_MAC_SAT_EN: accumulate saturates
// instead of wrapping (load mode unaffected).
module dsp_mac_sched
  import dsp_mac_sched_pkg::*;
#(
  parameter int NREQ      = DEF_NREQ,
  parameter int WIDTH     = DEF_WIDTH,
  parameter int ACC_WIDTH = DEF_ACC_WIDTH,
  parameter int MUL_LAT   = DEF_MUL_LAT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  input  logic [NREQ-1:0]       req_acc,
  output logic [WIDTH-1:0]      dsp_a,
  output logic [WIDTH-1:0]      dsp_b,
  input  logic [2*WIDTH-1:0]    dsp_p,
  output logic [NREQ-1:0]       rsp_valid,
  output logic [ACC_WIDTH-1:0]  rsp_data,
  output logic [NREQ-1:0]       busy
);

  localparam int ID_W = id_width(NREQ);

  logic [NREQ-1:0]      elig;
  logic [NREQ-1:0]      grant;
  logic                 hs;
  logic [ID_W-1:0]      gid;
  logic [ID_W-1:0]      ptr_q;

  // Tag stage 0 lines up with dsp_a/dsp_b, stage MUL_LAT with dsp_p.
  logic                 tag_vld [MUL_LAT+1];
  logic [ID_W-1:0]      tag_id  [MUL_LAT+1];
  logic                 tag_acc [MUL_LAT+1];

  logic                 wb;
  logic [ID_W-1:0]      wb_id;
  logic                 wb_acc;
  logic [NREQ-1:0]      wb_mask;

  logic [ACC_WIDTH-1:0] acc_q [NREQ];
  logic [ACC_WIDTH-1:0] acc_cur;
  logic [ACC_WIDTH-1:0] acc_sum;
  logic [ACC_WIDTH-1:0] acc_new;
  logic signed [2*WIDTH-1:0]   dsp_p_s;
  logic signed [ACC_WIDTH-1:0] p_ext;

  assign elig      = req_valid & ~busy;
  assign req_ready = grant;
  assign hs        = |grant;

  dsp_mac_sched_rr_arbiter #(
    .N     (NREQ),
    .PTR_W (ID_W)
  ) u_arb (
    .elig  (elig),
    .ptr   (ptr_q),
    .grant (grant)
  );

  // Encode the one-hot grant into a requester id.
  always_comb begin
    gid = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) gid = ID_W'(i);
    end
  end

  assign wb      = tag_vld[MUL_LAT];
  assign wb_id   = tag_id[MUL_LAT];
  assign wb_acc  = tag_acc[MUL_LAT];
  assign dsp_p_s = dsp_p;
  assign p_ext   = ACC_WIDTH'(dsp_p_s);
  assign acc_cur = acc_q[wb_id];
  assign acc_sum = acc_cur + p_ext;

  // One-hot of the requester being written back this cycle.
  always_comb begin
    wb_mask = '0;
    if (wb) wb_mask[wb_id] = 1'b1;
  end

  // New accumulator value: load or add, clamped on signed overflow when enabled.
  always_comb begin
    acc_new = wb_acc ? acc_sum : p_ext;
`ifdef DSP_MAC_SAT_EN
    if (wb_acc && (acc_cur[ACC_WIDTH-1] == p_ext[ACC_WIDTH-1]) &&
        (acc_sum[ACC_WIDTH-1] != acc_cur[ACC_WIDTH-1])) begin
      acc_new = acc_cur[ACC_WIDTH-1] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                     : {1'b0, {(ACC_WIDTH-1){1'b1}}};
    end
`endif
  end

  // Round-robin pointer moves past the requester just accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else if (hs) begin
      ptr_q <= (gid == ID_W'(NREQ - 1)) ? '0 : gid + 1'b1;
    end
  end

  // Operand registers toward the DSP; hold when nothing is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dsp_a <= '0;
      dsp_b <= '0;
    end else if (hs) begin
      dsp_a <= req_a[gid*WIDTH +: WIDTH];
      dsp_b <= req_b[gid*WIDTH +: WIDTH];
    end
  end

  // Tag pipeline tracking in-flight operations alongside the DSP stages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s <= MUL_LAT; s++) begin
        tag_vld[s] <= 1'b0;
        tag_id[s]  <= '0;
        tag_acc[s] <= 1'b0;
      end
    end else begin
      tag_vld[0] <= hs;
      tag_id[0]  <= gid;
      tag_acc[0] <= req_acc[gid];
      for (int s = 1; s <= MUL_LAT; s++) begin
        tag_vld[s] <= tag_vld[s-1];
        tag_id[s]  <= tag_id[s-1];
        tag_acc[s] <= tag_acc[s-1];
      end
    end
  end

  // Busy sets on accept and clears on writeback; the two never hit the same bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '0;
    end else begin
      busy <= (busy & ~wb_mask) | grant;
    end
  end

  // Accumulator update and response strobe at writeback.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREQ; i++) acc_q[i] <= '0;
      rsp_valid <= '0;
      rsp_data  <= '0;
    end else begin
      rsp_valid <= wb_mask;
      if (wb) begin
        acc_q[wb_id] <= acc_new;
        rsp_data     <= acc_new;
      end
    end
  end

endmodule

// File: tb/tb_dsp_mac_sched.sv
// Directed self-checking bench for dsp_mac_sched with a behavioural 2-stage DSP model.
module tb_dsp_mac_sched;

  localparam int NREQ      = 4;
  localparam int WIDTH     = 16;
  localparam int ACC_WIDTH = 32;
  localparam int MUL_LAT   = 2;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic [NREQ-1:0]       req_acc;
  logic [WIDTH-1:0]      dsp_a;
  logic [WIDTH-1:0]      dsp_b;
  logic [2*WIDTH-1:0]    dsp_p;
  logic [NREQ-1:0]       rsp_valid;
  logic [ACC_WIDTH-1:0]  rsp_data;
  logic [NREQ-1:0]       busy;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  // DSP model: MUL_LAT=2 register stages from operands to product.
  logic signed [2*WIDTH-1:0] p0, p1;
  always @(posedge clk) begin
    p0 <= $signed(dsp_a) * $signed(dsp_b);
    p1 <= p0;
  end
  assign dsp_p = p1;

  dsp_mac_sched #(
    .NREQ(NREQ), .WIDTH(WIDTH), .ACC_WIDTH(ACC_WIDTH), .MUL_LAT(MUL_LAT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_acc(req_acc),
    .dsp_a(dsp_a), .dsp_b(dsp_b), .dsp_p(dsp_p),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy)
  );

  task automatic drive(input int i, input logic v, input logic [15:0] a,
                       input logic [15:0] b, input logic acc);
    req_valid[i]             = v;
    req_a[i*WIDTH +: WIDTH]  = a;
    req_b[i*WIDTH +: WIDTH]  = b;
    req_acc[i]               = acc;
  endtask

  task automatic idle_all();
    req_valid = '0;
    req_acc   = '0;
    req_a     = '0;
    req_b     = '0;
  endtask

  task automatic test_reset();
    idle_all();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    tests++;
    if ({req_ready, rsp_valid, busy} !== '0) begin
      fails++;
      $display("FAIL reset_ctrl: ready=%b rsp_valid=%b busy=%b, want all 0", req_ready, rsp_valid, busy);
    end
    tests++;
    if (dsp_a !== '0 || dsp_b !== '0 || rsp_data !== '0) begin
      fails++;
      $display("FAIL reset_data: dsp_a=%h dsp_b=%h rsp_data=%h, want 0", dsp_a, dsp_b, rsp_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_op();
    @(negedge clk);
    drive(0, 1'b1, 16'd3, 16'hFFFB, 1'b0);
    #1;
    tests++;
    if (req_ready !== 4'b0001) begin
      fails++; $display("FAIL single_ready: got %b want 0001", req_ready);
    end
    @(negedge clk);
    drive(0, 1'b0, 16'd0, 16'd0, 1'b0);
    #1;
    tests++;
    if (dsp_a !== 16'd3 || dsp_b !== 16'hFFFB || busy !== 4'b0001) begin
      fails++; $display("FAIL single_issue: dsp_a=%h dsp_b=%h busy=%b want 0003 fffb 0001", dsp_a, dsp_b, busy);
    end
    @(negedge clk);
    @(negedge clk);
    #1;
    tests++;
    if (rsp_valid !== 4'b0000) begin
      fails++; $display("FAIL single_early: rsp_valid=%b in cycle 3, want 0000", rsp_valid);
    end
    @(negedge clk);
    #1;
    tests++;
    if (rsp_valid !== 4'b0001 || rsp_data !== 32'hFFFFFFF1 || busy !== 4'b0000) begin
      fails++; $display("FAIL single_rsp: rsp_valid=%b data=%h busy=%b want 0001 fffffff1 0000", rsp_valid, rsp_data, busy);
    end
    @(negedge clk);
    #1;
    tests++;
    if (rsp_valid !== 4'b0000 || rsp_data !== 32'hFFFFFFF1) begin
      fails++; $display("FAIL single_hold: rsp_valid=%b data=%h want 0000 fffffff1", rsp_valid, rsp_data);
    end
  endtask

  task automatic test_accum_chain();
    int acc_cyc [3];
    int rsp_cyc [3];
    logic [31:0] exp_d [3];
    int na = 0;
    int nr = 0;
    exp_d[0] = 32'd20000; exp_d[1] = 32'd20056; exp_d[2] = 32'd20112;
    for (int k = 0; k < 3; k++) begin acc_cyc[k] = 0; rsp_cyc[k] = 0; end
    for (int c = 0; c < 40 && nr < 3; c++) begin
      @(negedge clk);
      if (na == 0)     drive(1, 1'b1, 16'd100, 16'd200, 1'b0);
      else if (na < 3) drive(1, 1'b1, 16'd7, 16'd8, 1'b1);
      else             drive(1, 1'b0, 16'd0, 16'd0, 1'b0);
      #1;
      if (req_ready[1] && na < 3) begin acc_cyc[na] = c; na++; end
      if (rsp_valid != '0) begin
        tests++;
        if (rsp_valid !== 4'b0010 || rsp_data !== exp_d[nr]) begin
          fails++; $display("FAIL chain_rsp%0d: rsp_valid=%b data=%0d want 0010 %0d", nr, rsp_valid, rsp_data, exp_d[nr]);
        end
        rsp_cyc[nr] = c;
        nr++;
      end
    end
    drive(1, 1'b0, 16'd0, 16'd0, 1'b0);
    tests++;
    if (nr != 3 || na != 3) begin
      fails++; $display("FAIL chain_count: accepts=%0d responses=%0d want 3 3", na, nr);
    end
    tests++;
    if (acc_cyc[1] - acc_cyc[0] != 4 || acc_cyc[2] - acc_cyc[1] != 4) begin
      fails++; $display("FAIL chain_spacing: accepts at %0d %0d %0d want spacing 4", acc_cyc[0], acc_cyc[1], acc_cyc[2]);
    end
    tests++;
    if (rsp_cyc[0] - acc_cyc[0] != 4 || rsp_cyc[2] - acc_cyc[2] != 4) begin
      fails++; $display("FAIL chain_latency: rsp-acc = %0d %0d want 4", rsp_cyc[0] - acc_cyc[0], rsp_cyc[2] - acc_cyc[2]);
    end
  endtask

  task automatic test_fairness();
    logic [3:0] eg, er, eb;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      for (int i = 0; i < NREQ; i++) drive(i, 1'b1, 16'(i + 1), 16'd2, 1'b0);
      #1;
      eg = 4'(1 << (c % 4));
      tests++;
      if (req_ready !== eg) begin
        fails++; $display("FAIL fair_grant c%0d: got %b want %b", c, req_ready, eg);
      end
      if (c >= 4) begin
        er = 4'(1 << ((c - 4) % 4));
        eb = ~eg;
        tests++;
        if (rsp_valid !== er || rsp_data !== 32'(((c - 4) % 4 + 1) * 2) || busy !== eb) begin
          fails++; $display("FAIL fair_rsp c%0d: rsp_valid=%b data=%0d busy=%b want %b %0d %b",
                            c, rsp_valid, rsp_data, busy, er, ((c - 4) % 4 + 1) * 2, eb);
        end
      end
    end
    idle_all();
    repeat (6) @(negedge clk);
  endtask

  task automatic test_overlap();
    @(negedge clk);
    drive(2, 1'b1, 16'hFFF9, 16'd9, 1'b0);
    #1;
    tests++;
    if (req_ready !== 4'b0100) begin
      fails++; $display("FAIL ovl_ready2: got %b want 0100", req_ready);
    end
    @(negedge clk);
    drive(2, 1'b0, 16'd0, 16'd0, 1'b0);
    drive(3, 1'b1, 16'd1000, 16'hFC18, 1'b0);
    #1;
    tests++;
    if (req_ready !== 4'b1000 || busy !== 4'b0100) begin
      fails++; $display("FAIL ovl_ready3: ready=%b busy=%b want 1000 0100", req_ready, busy);
    end
    @(negedge clk);
    drive(3, 1'b0, 16'd0, 16'd0, 1'b0);
    #1;
    tests++;
    if (busy !== 4'b1100) begin
      fails++; $display("FAIL ovl_busy: got %b want 1100", busy);
    end
    @(negedge clk);
    @(negedge clk);
    #1;
    tests++;
    if (rsp_valid !== 4'b0100 || rsp_data !== 32'hFFFFFFC1 || busy !== 4'b1000) begin
      fails++; $display("FAIL ovl_rsp2: rsp_valid=%b data=%h busy=%b want 0100 ffffffc1 1000", rsp_valid, rsp_data, busy);
    end
    @(negedge clk);
    #1;
    tests++;
    if (rsp_valid !== 4'b1000 || rsp_data !== 32'hFFF0BDC0 || busy !== 4'b0000) begin
      fails++; $display("FAIL ovl_rsp3: rsp_valid=%b data=%h busy=%b want 1000 fff0bdc0 0000", rsp_valid, rsp_data, busy);
    end
  endtask

  task automatic test_reset_mid();
    logic seen = 1'b0;
    logic got  = 1'b0;
    @(negedge clk);
    drive(0, 1'b1, 16'd5, 16'd5, 1'b0);
    #1;
    tests++;
    if (req_ready !== 4'b0001) begin
      fails++; $display("FAIL rmid_ready: got %b want 0001", req_ready);
    end
    @(negedge clk);
    drive(0, 1'b0, 16'd0, 16'd0, 1'b0);
    rst_n = 1'b0;
    #1;
    tests++;
    if ({req_ready, rsp_valid, busy} !== '0 || dsp_a !== '0 || dsp_b !== '0 || rsp_data !== '0) begin
      fails++; $display("FAIL rmid_clear: ready=%b rsp=%b busy=%b dsp_a=%h dsp_b=%h data=%h want 0",
                        req_ready, rsp_valid, busy, dsp_a, dsp_b, rsp_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) begin
      @(negedge clk);
      #1;
      if (rsp_valid != '0) seen = 1'b1;
    end
    tests++;
    if (seen !== 1'b0) begin
      fails++; $display("FAIL rmid_ghost: rsp_valid seen=%b for discarded op, want 0", seen);
    end
    @(negedge clk);
    drive(0, 1'b1, 16'd2, 16'd3, 1'b1);
    @(negedge clk);
    drive(0, 1'b0, 16'd0, 16'd0, 1'b0);
    for (int c = 0; c < 10 && !got; c++) begin
      @(negedge clk);
      #1;
      if (rsp_valid != '0) got = 1'b1;
    end
    tests++;
    if (!got || rsp_valid !== 4'b0001 || rsp_data !== 32'd6) begin
      fails++; $display("FAIL rmid_acc0: got=%b rsp_valid=%b data=%0d want 1 0001 6", got, rsp_valid, rsp_data);
    end
  endtask

  task automatic test_saturation();
    logic [31:0] exp_d [4];
    logic got;
    exp_d[0] = 32'h3FFF0001;
    exp_d[1] = 32'h7FFE0002;
`ifdef DSP_MAC_SAT_EN
    exp_d[2] = 32'h7FFFFFFF;
    exp_d[3] = 32'h7FFFFFFF;
`else
    exp_d[2] = 32'hBFFD0003;
    exp_d[3] = 32'hFFFC0004;
`endif
    for (int k = 0; k < 4; k++) begin
      got = 1'b0;
      @(negedge clk);
      drive(0, 1'b1, 16'h7FFF, 16'h7FFF, (k != 0));
      @(negedge clk);
      drive(0, 1'b0, 16'd0, 16'd0, 1'b0);
      for (int c = 0; c < 10 && !got; c++) begin
        @(negedge clk);
        #1;
        if (rsp_valid != '0) got = 1'b1;
      end
      tests++;
      if (!got || rsp_valid !== 4'b0001 || rsp_data !== exp_d[k]) begin
        fails++; $display("FAIL sat_step%0d: got=%b rsp_valid=%b data=%h want 1 0001 %h", k, got, rsp_valid, rsp_data, exp_d[k]);
      end
    end
  endtask

  initial begin
    idle_all();
    rst_n = 1'b0;
    test_reset();
    test_single_op();
    test_accum_chain();
    test_fairness();
    test_overlap();
    test_reset_mid();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
